// File: rtl/mux32_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux32_arb_pkg
// Brief    : Shared sizes and state type for the mux32 round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mux32_arb_pkg;

  localparam int NREQ  = 32;
  localparam int SEL_W = 5;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick32.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick32
// Brief    : Combinational circular first-set finder over 32 requests,
//            starting the scan at ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick32
  import mux32_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [NREQ-1:0]  w_rot;
  logic [SEL_W-1:0] w_off;

  always_comb begin
    w_rot = '0;
    w_off = '0;
    // Rotate right by ptr so the scan start lands on bit 0.
    for (int i = 0; i < NREQ; i++) begin
      w_rot[i] = req[SEL_W'(i) + ptr];
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = SEL_W'(i);
      end
    end
    found = |req;
    idx   = w_off + ptr;
  end

endmodule
`default_nettype wire

// File: rtl/mux32_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux32_rr_arbiter
// Brief    : Round-robin burst arbiter driving the select of a shared mux32,
//            with valid/ready handoff to the single downstream consumer.
// Revision : 1.0 - initial release
// ============================================================================
module mux32_rr_arbiter
  import mux32_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [SEL_W-1:0] sel,
  output logic [NREQ-1:0]  grant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NREQ-1:0]  ack
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(MAX_BURST - 1);
  localparam logic [NREQ-1:0]  c_one       = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_t       r_state, w_state_nxt;
  logic [SEL_W-1:0] r_ptr,   w_ptr_nxt;
  logic [SEL_W-1:0] r_sel,   w_sel_nxt;
  logic [NREQ-1:0]  r_grant, w_grant_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;

  logic             w_found;
  logic [SEL_W-1:0] w_idx;
  logic             w_busy;
  logic             w_xfer;
  logic             w_release;

  rr_pick32 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_busy    = (r_state == ARB_BUSY);
  assign out_valid = w_busy & req[r_sel];
  assign w_xfer    = out_valid & out_ready;
  assign ack       = w_xfer ? (c_one << r_sel) : '0;
  assign sel       = r_sel;
  assign grant     = r_grant;

  // A withdrawn owner releases without a beat; a full burst releases on its last beat.
  assign w_release = w_busy & ((w_xfer & (r_cnt == c_last_beat)) | ~req[r_sel]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_sel_nxt   = w_idx;
          w_grant_nxt = c_one << w_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // sel is left alone on release so the mux input never glitches.
        if (w_release) begin
          w_ptr_nxt   = r_sel + 1'b1;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ARB_IDLE;
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
